// File: rtl/z80_trace_pkg.sv
// Shared types for the Z80 bus tracer: record layout,
// cycle type codes and the strobe decoder.
package z80_trace_pkg;

  localparam int TS_W_DEF = 16;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    MEM_RD = 3'd1,
    MEM_WR = 3'd2,
    IO_RD  = 3'd3,
    IO_WR  = 3'd4,
    INTA   = 3'd5
  } ev_type_e;

  typedef struct packed {
    ev_type_e              typ;
    logic [15:0]           addr;
    logic [7:0]            data;
    logic [TS_W_DEF-1:0]   ts;
  } trace_rec_t;

  function automatic ev_type_e decode(
    input logic m1_n,
    input logic mreq_n,
    input logic iorq_n,
    input logic rd_n,
    input logic wr_n
  );
    ev_type_e t;
    if (!m1_n && !mreq_n && !rd_n)  t = FETCH;
    else if (!mreq_n && !rd_n)      t = MEM_RD;
    else if (!mreq_n && !wr_n)      t = MEM_WR;
    else if (!iorq_n && !m1_n)      t = INTA;
    else if (!iorq_n && !rd_n)      t = IO_RD;
    else if (!iorq_n && !wr_n)      t = IO_WR;
    else if (!wr_n)                 t = MEM_WR;
    else                            t = MEM_RD;
    return t;
  endfunction

  function automatic logic is_write(input ev_type_e t);
    return (t == MEM_WR) || (t == IO_WR);
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous record FIFO; extra pointer bit separates
// full from empty.
module trace_fifo
  import z80_trace_pkg::*;
#(
  parameter int  DEPTH = 16,
  parameter type rec_t = trace_rec_t
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic clear,
  input  rec_t wdata,
  output rec_t rdata,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  rec_t       mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/z80_bus_tracer.sv
// Passive Z80 bus observer: classifies each completed bus
// cycle and queues a timestamped record.
module z80_bus_tracer
  import z80_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int TS_W  = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            clear,
  input  logic            m1_n,
  input  logic            mreq_n,
  input  logic            iorq_n,
  input  logic            rd_n,
  input  logic            wr_n,
  input  logic            rfsh_n,
  input  logic [15:0]     A,
  input  logic [7:0]      di,
  input  logic [7:0]      dout,
  output logic            ev_valid,
  input  logic            ev_ready,
  output logic [2:0]      ev_type,
  output logic [15:0]     ev_addr,
  output logic [7:0]      ev_data,
  output logic [TS_W-1:0] ev_ts,
  output logic            overflow,
  output logic [7:0]      drop_cnt
);

  typedef struct packed {
    ev_type_e          typ;
    logic [15:0]       addr;
    logic [7:0]        data;
    logic [TS_W-1:0]   ts;
  } rec_t;

  logic            act;
  logic            act_q;
  logic            tracing;
  ev_type_e        cur_type;
  ev_type_e        cap_type;
  logic [15:0]     cap_addr;
  logic [7:0]      cap_data;
  logic [TS_W-1:0] ts;
  logic [TS_W-1:0] ts_start;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  rec_t            wrec;
  rec_t            head;

  assign act = (!rd_n || !wr_n || (!iorq_n && !m1_n)) && rfsh_n;
  assign cur_type = decode(m1_n, mreq_n, iorq_n, rd_n, wr_n);

  // tracing marks a cycle that began enabled and stayed enabled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts       <= '0;
      ts_start <= '0;
      act_q    <= 1'b0;
      tracing  <= 1'b0;
      cap_type <= FETCH;
      cap_addr <= '0;
      cap_data <= '0;
    end else begin
      ts    <= ts + 1'b1;
      act_q <= act;
      if (act && enable) begin
        cap_type <= cur_type;
        cap_addr <= A;
        cap_data <= is_write(cur_type) ? dout : di;
      end
      if (act && !act_q) begin
        tracing  <= enable;
        ts_start <= ts;
      end else if (!act || !enable) begin
        tracing <= 1'b0;
      end
    end
  end

  assign push = enable && tracing && act_q && !act;
  assign pop  = !empty && ev_ready;

  assign wrec = '{typ: cap_type, addr: cap_addr,
                  data: cap_data, ts: ts_start};

  trace_fifo #(
    .DEPTH (DEPTH),
    .rec_t (rec_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .clear (clear),
    .wdata (wrec),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clear) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (push && full && !pop) begin
      overflow <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign ev_valid = !empty;
  assign ev_type  = head.typ;
  assign ev_addr  = head.addr;
  assign ev_data  = head.data;
  assign ev_ts    = head.ts;

endmodule

// File: tb/tb_z80_bus_tracer.sv
// Self-checking bench for z80_bus_tracer: directed table,
// corner sequences and random traffic against a queue model.
module tb_z80_bus_tracer;

  localparam int DEPTH = 4;

  typedef struct {
    logic [2:0]  typ;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [15:0] ts;
  } rec_s;

  typedef struct {
    logic [2:0]  kind;
    logic [15:0] addr;
    logic [7:0]  data;
    int          len;
    bit          has_rec;
    logic [2:0]  exp_type;
    logic [15:0] exp_addr;
    logic [7:0]  exp_data;
  } vec_s;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        clear;
  logic        m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;
  logic [15:0] A;
  logic [7:0]  di;
  logic [7:0]  dout;
  logic        ev_valid;
  logic        ev_ready;
  logic [2:0]  ev_type;
  logic [15:0] ev_addr;
  logic [7:0]  ev_data;
  logic [15:0] ev_ts;
  logic        overflow;
  logic [7:0]  drop_cnt;

  logic [15:0] ecount;
  rec_s        q[$];
  bit          m_ovf;
  int          m_drop;
  bit          rand_rdy;
  int          n_pass;
  int          n_chk;

  z80_bus_tracer #(.DEPTH(DEPTH), .TS_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .clear    (clear),
    .m1_n     (m1_n),
    .mreq_n   (mreq_n),
    .iorq_n   (iorq_n),
    .rd_n     (rd_n),
    .wr_n     (wr_n),
    .rfsh_n   (rfsh_n),
    .A        (A),
    .di       (di),
    .dout     (dout),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_type  (ev_type),
    .ev_addr  (ev_addr),
    .ev_data  (ev_data),
    .ev_ts    (ev_ts),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // elapsed clocks since reset release = expected timestamp
  always @(posedge clk or posedge reset) begin
    if (reset) ecount <= '0;
    else       ecount <= ecount + 16'd1;
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(ev_valid), 0);
    chk({tag, "_type"}, 32'(ev_type), 0);
    chk({tag, "_addr"}, 32'(ev_addr), 0);
    chk({tag, "_data"}, 32'(ev_data), 0);
    chk({tag, "_ts"}, 32'(ev_ts), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
    chk({tag, "_drop"}, 32'(drop_cnt), 0);
  endtask

  task automatic idle();
    m1_n = 1; mreq_n = 1; iorq_n = 1;
    rd_n = 1; wr_n = 1; rfsh_n = 1;
  endtask

  task automatic drive(input logic [2:0] kind, input logic [15:0] addr,
                       input logic [7:0] data);
    idle();
    A = addr;
    di = 8'($urandom);
    dout = 8'($urandom);
    case (kind)
      3'd0: begin m1_n = 0; mreq_n = 0; rd_n = 0; di = data; end
      3'd1: begin mreq_n = 0; rd_n = 0; di = data; end
      3'd2: begin mreq_n = 0; wr_n = 0; dout = data; end
      3'd3: begin iorq_n = 0; rd_n = 0; di = data; end
      3'd4: begin iorq_n = 0; wr_n = 0; dout = data; end
      3'd5: begin m1_n = 0; iorq_n = 0; di = data; end
      default: begin rfsh_n = 0; mreq_n = 0; rd_n = 0; end
    endcase
  endtask

  task automatic compare();
    chk("ev_valid", 32'(ev_valid), 32'(q.size() > 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    if (q.size() > 0) begin
      chk("head_type", 32'(ev_type), 32'(q[0].typ));
      chk("head_addr", 32'(ev_addr), 32'(q[0].addr));
      chk("head_data", 32'(ev_data), 32'(q[0].data));
      chk("head_ts", 32'(ev_ts), 32'(q[0].ts));
    end
  endtask

  // one clock; model applies clear, then pop, then push
  task automatic step(input bit push, input rec_s r);
    bit pop;
    bit clr;
    if (rand_rdy) ev_ready = 1'($urandom_range(0, 1));
    pop = (q.size() > 0) && ev_ready;
    clr = clear;
    @(posedge clk);
    #1;
    if (clr) begin
      q.delete();
      m_ovf = 0;
      m_drop = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        if (q.size() < DEPTH) q.push_back(r);
        else begin
          m_ovf = 1;
          if (m_drop < 255) m_drop++;
        end
      end
    end
    compare();
  endtask

  task automatic run_cycle(input logic [2:0] kind, input logic [15:0] addr,
                           input logic [7:0] data, input int len,
                           input bit traced);
    rec_s r;
    r.typ = kind;
    r.addr = addr;
    r.data = data;
    r.ts = ecount;
    drive(kind, addr, data);
    repeat (len) step(0, r);
    idle();
    step(traced && (kind < 3'd6), r);
  endtask

  vec_s   tbl[$];
  rec_s   r;
  int     n;
  logic [15:0] last_ts;

  initial begin
    n_pass = 0; n_chk = 0; m_ovf = 0; m_drop = 0;
    rand_rdy = 0;
    reset = 1; enable = 1; clear = 0; ev_ready = 1;
    A = 0; di = 0; dout = 0;
    idle();
    r = '{typ: 0, addr: 0, data: 0, ts: 0};
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    reset = 0;

    tbl.push_back('{3'd0, 16'h0000, 8'hCB, 2, 1, 3'd0, 16'h0000, 8'hCB});
    tbl.push_back('{3'd6, 16'h0000, 8'h00, 1, 0, 3'd0, 16'h0000, 8'h00});
    tbl.push_back('{3'd0, 16'h0001, 8'hA0, 2, 1, 3'd0, 16'h0001, 8'hA0});
    tbl.push_back('{3'd6, 16'h0001, 8'h00, 1, 0, 3'd0, 16'h0000, 8'h00});
    tbl.push_back('{3'd0, 16'h0002, 8'h32, 2, 1, 3'd0, 16'h0002, 8'h32});
    tbl.push_back('{3'd2, 16'h1234, 8'h5A, 2, 1, 3'd2, 16'h1234, 8'h5A});
    tbl.push_back('{3'd4, 16'h5A7F, 8'h5A, 3, 1, 3'd4, 16'h5A7F, 8'h5A});
    tbl.push_back('{3'd1, 16'hC80D, 8'hC0, 3, 1, 3'd1, 16'hC80D, 8'hC0});
    tbl.push_back('{3'd3, 16'h0010, 8'h77, 1, 1, 3'd3, 16'h0010, 8'h77});
    tbl.push_back('{3'd5, 16'h00FF, 8'hFF, 2, 1, 3'd5, 16'h00FF, 8'hFF});
    tbl.push_back('{3'd2, 16'hFFFF, 8'h00, 1, 1, 3'd2, 16'hFFFF, 8'h00});

    last_ts = 0;
    foreach (tbl[i]) begin
      run_cycle(tbl[i].kind, tbl[i].addr, tbl[i].data, tbl[i].len, 1);
      if (tbl[i].has_rec) begin
        chk("tbl_valid", 32'(ev_valid), 1);
        chk("tbl_type", 32'(ev_type), 32'(tbl[i].exp_type));
        chk("tbl_addr", 32'(ev_addr), 32'(tbl[i].exp_addr));
        chk("tbl_data", 32'(ev_data), 32'(tbl[i].exp_data));
        chk("tbl_ts_incr", 32'(ev_ts > last_ts || i == 0), 1);
        last_ts = ev_ts;
      end else begin
        chk("tbl_no_rec", 32'(ev_valid), 0);
      end
    end

    // last active sample wins
    r.ts = ecount;
    drive(3'd1, 16'h1111, 8'h11);
    step(0, r);
    drive(3'd1, 16'h2222, 8'h22);
    step(0, r);
    idle();
    r.typ = 3'd1; r.addr = 16'h2222; r.data = 8'h22;
    step(1, r);
    chk("last_wins_addr", 32'(ev_addr), 32'h2222);

    // enable falls mid-fetch: cycle discarded
    drive(3'd0, 16'h0100, 8'h3E);
    step(0, r);
    enable = 0;
    step(0, r);
    enable = 1;
    step(0, r);
    idle();
    step(0, r);
    chk("en_drop_valid", 32'(ev_valid), 0);
    run_cycle(3'd1, 16'h0101, 8'h42, 2, 1);
    chk("en_next_addr", 32'(ev_addr), 32'h0101);

    // cycle starting while disabled is never traced
    enable = 0;
    drive(3'd2, 16'h0200, 8'h99);
    step(0, r);
    enable = 1;
    step(0, r);
    idle();
    step(0, r);
    chk("en_late_valid", 32'(ev_valid), 0);

    run_cycle(3'd6, 16'h0300, 8'h00, 4, 1);
    chk("rfsh_valid", 32'(ev_valid), 0);

    // overflow with consumer stalled
    ev_ready = 0;
    for (int i = 0; i < 6; i++)
      run_cycle(3'($urandom_range(0, 5)), 16'($urandom), 8'($urandom), 1, 1);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_drop", 32'(drop_cnt), 2);
    ev_ready = 1;
    repeat (DEPTH) step(0, r);
    chk("ovf_drained", 32'(ev_valid), 0);
    chk("ovf_sticky", 32'(overflow), 1);

    // full with push and pop on the same edge
    clear = 1;
    step(0, r);
    clear = 0;
    ev_ready = 0;
    for (int i = 0; i < DEPTH; i++)
      run_cycle(3'($urandom_range(0, 5)), 16'($urandom), 8'($urandom), 1, 1);
    r.ts = ecount;
    drive(3'd2, 16'hBEEF, 8'h99);
    step(0, r);
    idle();
    ev_ready = 1;
    r.typ = 3'd2; r.addr = 16'hBEEF; r.data = 8'h99;
    step(1, r);
    ev_ready = 0;
    chk("pp_drop", 32'(drop_cnt), 0);
    chk("pp_ovf", 32'(overflow), 0);
    ev_ready = 1;
    n = 0;
    while (ev_valid && n < 10) begin
      step(0, r);
      n++;
    end
    chk("pp_count", 32'(n), 32'(DEPTH));

    // drop counter saturation
    ev_ready = 0;
    for (int i = 0; i < 262; i++)
      run_cycle(3'($urandom_range(0, 5)), 16'($urandom), 8'($urandom), 1, 1);
    chk("drop_sat", 32'(drop_cnt), 32'hFF);

    // clear with a coincident push
    r.ts = ecount;
    drive(3'd4, 16'h0042, 8'h24);
    step(0, r);
    idle();
    clear = 1;
    step(1, r);
    clear = 0;
    chk("clr_valid", 32'(ev_valid), 0);
    chk("clr_ovf", 32'(overflow), 0);
    chk("clr_drop", 32'(drop_cnt), 0);

    // reset mid-cycle with a record pending
    run_cycle(3'd1, 16'h4000, 8'h12, 1, 1);
    drive(3'd2, 16'h5000, 8'h34);
    step(0, r);
    reset = 1;
    @(posedge clk);
    #1;
    chk_zero("rst_mid");
    idle();
    reset = 0;
    q.delete();
    m_ovf = 0;
    m_drop = 0;
    ev_ready = 1;
    run_cycle(3'd3, 16'h0042, 8'h55, 1, 1);
    chk("rst_ts_small", 32'(ev_ts < 16), 1);
    chk("rst_rec_valid", 32'(ev_valid), 1);

    // random traffic with random back-pressure
    rand_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      run_cycle(3'($urandom_range(0, 6)), 16'($urandom), 8'($urandom),
                $urandom_range(1, 3), 1);
      repeat ($urandom_range(0, 2)) step(0, r);
    end
    rand_rdy = 0;
    ev_ready = 1;
    repeat (DEPTH + 1) step(0, r);
    chk("final_empty", 32'(ev_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
